// File: rtl/ps2_key_if.sv
// PS/2 pin pair plus the decoded key word and its status pulses.
// master drives the pins (keyboard side); slave is the decoder.
interface ps2_key_if;
  logic        ps2_clk_in;
  logic        ps2_data_in;
  logic [10:0] ps2_key;
  logic        key_strobe;
  logic        frame_error;

  modport master (
    output ps2_clk_in,
    output ps2_data_in,
    input  ps2_key,
    input  key_strobe,
    input  frame_error
  );

  modport slave (
    input  ps2_clk_in,
    input  ps2_data_in,
    output ps2_key,
    output key_strobe,
    output frame_error
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard receiver.
// Turns the raw clock/data pins into an 11-bit {toggle, pressed, extended, scancode} word.
module ps2_key_decoder #(
  parameter int FILTER_LEN = 16,
  parameter int TIMEOUT    = 48000
) (
  input  logic      clk,
  input  logic      reset,
  ps2_key_if.slave  bus
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [FCW-1:0] FLT_MAX = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TMO_LIM = TCW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  function automatic logic is_status(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_status = 1'b1;
      default:                                         is_status = 1'b0;
    endcase
  endfunction

  // Input conditioning: index 0 is the clock line, index 1 the data line.
  logic [1:0]          meta_q, sync_q, filt_q, filt_d;
  logic [1:0][FCW-1:0] cnt_q, cnt_d;
  logic                clk_prev_q;
  logic                fall, din;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q     <= 2'b11;
      sync_q     <= 2'b11;
      filt_q     <= 2'b11;
      cnt_q      <= '0;
      clk_prev_q <= 1'b1;
    end else begin
      meta_q     <= {bus.ps2_data_in, bus.ps2_clk_in};
      sync_q     <= meta_q;
      filt_q     <= filt_d;
      cnt_q      <= cnt_d;
      clk_prev_q <= filt_q[0];
    end
  end

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i] != filt_q[i]) begin
        if (cnt_q[i] == FLT_MAX) begin
          filt_d[i] = sync_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  assign fall = clk_prev_q & ~filt_q[0];
  assign din  = filt_q[1];

  // Frame receiver
  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic           byte_ok, byte_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    shift_d   = shift_q;
    par_d     = par_q;
    byte_ok   = 1'b0;
    byte_err  = 1'b0;
    if (state_q == S_IDLE) begin
      tmo_d = '0;
      if (fall && !din) begin
        state_d   = S_DATA;
        bit_cnt_d = '0;
      end
    end else if (fall) begin
      tmo_d = '0;
      case (state_q)
        S_DATA: begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = din;
          state_d = S_STOP;
        end
        default: begin
          if (din && (^{shift_q, par_q})) byte_ok  = 1'b1;
          else                            byte_err = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end else if (tmo_q == TMO_LIM) begin
      // Stalled partial frame: drop it quietly, prefix state survives.
      state_d = S_IDLE;
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Byte decoder and registered outputs
  logic        ext_q, ext_d, brk_q, brk_d;
  logic [2:0]  skip_q, skip_d;
  logic [10:0] key_q, key_d;
  logic        strobe_q, strobe_d, ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      skip_q   <= '0;
      key_q    <= '0;
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      skip_q   <= skip_d;
      key_q    <= key_d;
      strobe_q <= strobe_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    ext_d    = ext_q;
    brk_d    = brk_q;
    skip_d   = skip_q;
    key_d    = key_q;
    strobe_d = 1'b0;
    ferr_d   = 1'b0;
    if (byte_err) begin
      ferr_d = 1'b1;
      ext_d  = 1'b0;
      brk_d  = 1'b0;
    end else if (byte_ok) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else if (shift_q == 8'hE1) begin
        // Pause: E1 is followed by seven bytes that carry no key event.
        skip_d = 3'd7;
        ext_d  = 1'b0;
        brk_d  = 1'b0;
      end else if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (is_status(shift_q) && !ext_q && !brk_q) begin
        skip_d = skip_q;
      end else begin
        key_d    = {~key_q[10], ~brk_q, ext_q, shift_q};
        strobe_d = 1'b1;
        ext_d    = 1'b0;
        brk_d    = 1'b0;
      end
    end
  end

  assign bus.ps2_key     = key_q;
  assign bus.key_strobe  = strobe_q;
  assign bus.frame_error = ferr_q;

endmodule
